// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned PC_MAX_W = 16;
   localparam int unsigned OPC_W    = 4;

   // Instruction field bit positions: opcode[15:12] rd[11:8] rs1[7:4] rs2[3:0]
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 8;
   localparam int unsigned RS1_MSB = 7;
   localparam int unsigned RS1_LSB = 4;
   localparam int unsigned RS2_MSB = 3;
   localparam int unsigned RS2_LSB = 0;

   localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OPC_W-1:0] OP_LOAD = 4'h2;
   localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

   // pc field is sized for the widest supported fetch address
   typedef struct packed {
      logic [INSTR_W-1:0]  instr;
      logic [PC_MAX_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 8
);
   import ifetch_pkg::*;

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic [INSTR_W-1:0]  imem_rdata;
   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;
   logic                instr_valid;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_pc;
   logic                instr_ready;
   logic                halted;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      input  imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      output imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch queue of fetch entries: synchronous FIFO with push/pop/flush and occupancy.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  fetch_entry_t     i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output fetch_entry_t     o_head_c,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [CNT_W-1:0] w_count_nxt;

   // Flush wins over both push and pop
   always_comb begin
      w_do_pop    = i_pop && !i_flush && !r_empty;
      w_do_push   = i_push && !i_flush && (!r_full || w_do_pop);
      w_count_nxt = r_count;
      if (i_flush) begin
         w_count_nxt = '0;
      end else if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head_c = r_mem[r_rd_ptr];
   assign o_count  = r_count;
   assign o_full   = r_full;
   assign o_empty  = r_empty;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC sequencing, credit-limited imem reads, prefetch queue to decode.
// Optional HALT handling (opcode 4'hF stops fetch) is built when IFETCH_HALT_EN is defined.
module instr_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_unit_if.master bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned CRD_W = CNT_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'(FS_IDLE);
   localparam logic [1:0] ST_RUN    = 2'(FS_RUN);
`ifdef IFETCH_HALT_EN
   localparam logic [1:0] ST_HALTED = 2'(FS_HALTED);
`endif

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;
   fetch_entry_t      r_hold;

   logic [1:0]        w_state_nxt;
   logic              w_issue_c;
   logic              w_push;
   logic              w_pop_c;
   logic              w_redirect;
   logic [CRD_W-1:0]  w_credit_c;
   fetch_entry_t      w_entry;
   fetch_entry_t      w_head;
   fetch_entry_t      w_shown;
   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_unused_c;

   assign w_redirect = bus.redirect_valid;
   assign w_pop_c    = !w_empty && bus.instr_ready;
   assign w_entry    = '{instr: bus.imem_rdata, pc: PC_MAX_W'(r_inflight_pc)};

   // Slots already owed to the queue, less the one decode frees this cycle
   assign w_credit_c = CRD_W'(w_count) + CRD_W'(r_inflight) - CRD_W'(w_pop_c);

`ifdef IFETCH_HALT_EN
   logic w_halt_hit;
   logic r_halted;
   assign w_halt_hit = r_inflight && (get_opcode(bus.imem_rdata) == OP_HALT);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_issue_c   = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!w_redirect) begin
               w_push    = r_inflight;
               w_issue_c = (w_credit_c < CRD_W'(DEPTH));
`ifdef IFETCH_HALT_EN
               if (w_halt_hit) w_state_nxt = ST_HALTED;
`endif
            end
         end
`ifdef IFETCH_HALT_EN
         ST_HALTED: begin
            if (w_redirect) w_state_nxt = ST_RUN;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_hold        <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue_c;
         r_hold     <= w_shown;
         if (w_issue_c) r_inflight_pc <= r_pc;
         if (w_redirect) begin
            r_pc <= bus.redirect_pc;
         end else if (w_issue_c) begin
            r_pc <= r_pc + ADDR_W'(1);
         end
      end
   end

`ifdef IFETCH_HALT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_halted <= 1'b0;
      end else begin
         r_halted <= (w_state_nxt == ST_HALTED);
      end
   end
   assign bus.halted = r_halted;
`else
   assign bus.halted = 1'b0;
`endif

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_push   (w_push),
      .i_data   (w_entry),
      .i_pop    (w_pop_c),
      .i_flush  (w_redirect),
      .o_head_c (w_head),
      .o_count  (w_count),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // With the queue empty the last presented word stays on the outputs
   assign w_shown         = w_empty ? r_hold : w_head;
   assign bus.instr_valid = !w_empty;
   assign bus.instr       = w_shown.instr;
   assign bus.instr_pc    = ADDR_W'(w_shown.pc);
   assign bus.imem_req    = w_issue_c;
   assign bus.imem_addr   = r_pc;

   assign w_unused_c = ^{w_full, w_shown.pc};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a one-cycle-latency imem model.
module tb_instr_fetch_unit;
   import ifetch_pkg::*;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 4;

   localparam logic [15:0] SEQ_I [5] = '{16'h0123, 16'h1413, 16'h2580, 16'h3003, 16'h3004};
   localparam logic [7:0]  WRAP_PC [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
   localparam logic [15:0] WRAP_I  [4] = '{16'h30FE, 16'h30FF, 16'h0123, 16'h1413};

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   logic [15:0] imem [256];

   instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= imem[bus.imem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset(input logic rdy);
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = rdy;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) imem[i] = {8'h30, 8'(i)};
      imem[0] = 16'h0123;
      imem[1] = 16'h1413;
      imem[2] = 16'h2580;
      do_reset(1'b1);
      settle();
      n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", bus.imem_req); else n_pass++;
      n_chk++; if (bus.imem_addr !== 8'h00) $display("FAIL rst_addr: got %0h want 0", bus.imem_addr); else n_pass++;
      n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", bus.instr_valid); else n_pass++;
      n_chk++; if (bus.instr !== 16'h0000) $display("FAIL rst_instr: got %0h want 0", bus.instr); else n_pass++;
      n_chk++; if (bus.instr_pc !== 8'h00) $display("FAIL rst_pc: got %0h want 0", bus.instr_pc); else n_pass++;
      n_chk++; if (bus.halted !== 1'b0) $display("FAIL rst_halted: got %0h want 0", bus.halted); else n_pass++;
   endtask

   task automatic test_sequential();
      step(); settle();
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00)
         $display("FAIL seq_c1_req: got req=%0h addr=%0h want req=1 addr=0", bus.imem_req, bus.imem_addr); else n_pass++;
      step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01)
         $display("FAIL seq_c2: got valid=%0h req=%0h addr=%0h want 0/1/1", bus.instr_valid, bus.imem_req, bus.imem_addr); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         step(); settle();
         n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr !== SEQ_I[k] || bus.instr_pc !== 8'(k))
            $display("FAIL seq_c%0d: got valid=%0h instr=%h pc=%0h want 1/%h/%0h",
                     cyc, bus.instr_valid, bus.instr, bus.instr_pc, SEQ_I[k], k); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int n_req;
      int got;
      n_req = 0;
      got = 0;
      do_reset(1'b0);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) step();
         settle();
         if (bus.imem_req === 1'b1) n_req++;
         if (c >= 5) begin
            n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL bp_full_req_c%0d: got %0h want 0", cyc, bus.imem_req); else n_pass++;
         end
      end
      n_chk++; if (n_req != DEPTH) $display("FAIL bp_nreq: got %0d want %0d", n_req, DEPTH); else n_pass++;
      step();
      bus.instr_ready = 1'b1;
      for (int c = 0; c < 20 && got < 5; c++) begin
         if (c > 0) step();
         settle();
         if (bus.instr_valid === 1'b1) begin
            n_chk++; if (bus.instr_pc !== 8'(got) || bus.instr !== SEQ_I[got])
               $display("FAIL bp_xfer%0d: got pc=%0h instr=%h want pc=%0h instr=%h",
                        got, bus.instr_pc, bus.instr, got, SEQ_I[got]); else n_pass++;
            got++;
         end
      end
      n_chk++; if (got != 5) $display("FAIL bp_count: got %0d transfers want 5", got); else n_pass++;
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      settle();
      repeat (5) step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'h40;
      settle();
      n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rd_req_R: got %0h want 0", bus.imem_req); else n_pass++;
      step();
      bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      settle();
      n_chk++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40)
         $display("FAIL rd_R1: got valid=%0h req=%0h addr=%0h want 0/1/40", bus.instr_valid, bus.imem_req, bus.imem_addr); else n_pass++;
      step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h41)
         $display("FAIL rd_R2: got valid=%0h addr=%0h want 0/41", bus.instr_valid, bus.imem_addr); else n_pass++;
      step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr !== 16'h3040)
         $display("FAIL rd_R3: got valid=%0h pc=%0h instr=%h want 1/40/3040", bus.instr_valid, bus.instr_pc, bus.instr); else n_pass++;
      step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h41)
         $display("FAIL rd_R4: got valid=%0h pc=%0h want 1/41", bus.instr_valid, bus.instr_pc); else n_pass++;
   endtask

   task automatic test_wrap();
      int r_cyc;
      int first;
      int got;
      got = 0;
      first = -1;
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'hFE;
      r_cyc = cyc;
      for (int c = 0; c < 12 && got < 4; c++) begin
         step();
         if (c == 0) bus.redirect_valid = 1'b0;
         settle();
         if (bus.instr_valid === 1'b1) begin
            if (got == 0) first = cyc;
            n_chk++; if (bus.instr_pc !== WRAP_PC[got] || bus.instr !== WRAP_I[got])
               $display("FAIL wrap_xfer%0d: got pc=%0h instr=%h want pc=%0h instr=%h",
                        got, bus.instr_pc, bus.instr, WRAP_PC[got], WRAP_I[got]); else n_pass++;
            got++;
         end
      end
      n_chk++; if (got != 4) $display("FAIL wrap_count: got %0d want 4", got); else n_pass++;
      n_chk++; if (first != r_cyc + 3) $display("FAIL wrap_latency: got cycle %0d want %0d", first, r_cyc + 3); else n_pass++;
   endtask

`ifdef IFETCH_HALT_EN
   task automatic test_halt();
      int got;
      int n_late;
      logic [15:0] last_i;
      got = 0;
      n_late = 0;
      last_i = '0;
      imem[3] = 16'hF000;
      do_reset(1'b1);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step();
         settle();
         if (c >= 6 && bus.imem_req === 1'b1) n_late++;
         if (bus.instr_valid === 1'b1) begin
            n_chk++; if (bus.instr_pc !== 8'(got)) $display("FAIL halt_pc%0d: got %0h want %0h", got, bus.instr_pc, got); else n_pass++;
            last_i = bus.instr;
            got++;
         end
      end
      n_chk++; if (got != 4) $display("FAIL halt_count: got %0d want 4", got); else n_pass++;
      n_chk++; if (last_i !== 16'hF000) $display("FAIL halt_word: got %h want f000", last_i); else n_pass++;
      n_chk++; if (n_late != 0) $display("FAIL halt_req: got %0d late requests want 0", n_late); else n_pass++;
      n_chk++; if (bus.halted !== 1'b1) $display("FAIL halt_flag: got %0h want 1", bus.halted); else n_pass++;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'h00;
      step();
      bus.redirect_valid = 1'b0;
      settle();
      n_chk++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00)
         $display("FAIL halt_restart: got halted=%0h req=%0h addr=%0h want 0/1/0", bus.halted, bus.imem_req, bus.imem_addr); else n_pass++;
      step(); step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== 16'h0123)
         $display("FAIL halt_resume: got valid=%0h pc=%0h instr=%h want 1/0/0123", bus.instr_valid, bus.instr_pc, bus.instr); else n_pass++;
      imem[3] = 16'h3003;
   endtask
`else
   task automatic test_halt();
      int got;
      got = 0;
      imem[3] = 16'hF000;
      do_reset(1'b1);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) step();
         settle();
         if (bus.instr_valid === 1'b1) begin
            n_chk++; if (bus.instr_pc !== 8'(got) || (got == 3 && bus.instr !== 16'hF000))
               $display("FAIL nohalt_xfer%0d: got pc=%0h instr=%h want pc=%0h", got, bus.instr_pc, bus.instr, got); else n_pass++;
            got++;
         end
      end
      n_chk++; if (got != 7) $display("FAIL nohalt_count: got %0d want 7", got); else n_pass++;
      n_chk++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1)
         $display("FAIL nohalt_state: got halted=%0h req=%0h want 0/1", bus.halted, bus.imem_req); else n_pass++;
      imem[3] = 16'h3003;
   endtask
`endif

   task automatic test_reset_mid();
      do_reset(1'b0);
      settle();
      repeat (8) step();
      settle();
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0123)
         $display("FAIL rm_pre: got valid=%0h instr=%h want 1/0123", bus.instr_valid, bus.instr); else n_pass++;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'h80;
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b1;
      cyc = 0;
      settle();
      n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00)
         $display("FAIL rm_req: got req=%0h addr=%0h want 0/0", bus.imem_req, bus.imem_addr); else n_pass++;
      n_chk++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 8'h00)
         $display("FAIL rm_out: got valid=%0h instr=%h pc=%0h want 0/0000/0", bus.instr_valid, bus.instr, bus.instr_pc); else n_pass++;
      n_chk++; if (bus.halted !== 1'b0) $display("FAIL rm_halted: got %0h want 0", bus.halted); else n_pass++;
      step(); settle();
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00)
         $display("FAIL rm_c1: got req=%0h addr=%0h want 1/0", bus.imem_req, bus.imem_addr); else n_pass++;
      step(); step(); settle();
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr !== 16'h0123)
         $display("FAIL rm_c3: got valid=%0h pc=%0h instr=%h want 1/0/0123", bus.instr_valid, bus.instr_pc, bus.instr); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
